axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_arb_pkg.sv | 24 ++
 rtl/arb_starve_cnt.sv | 30 +++
 rtl/axi_rd_arbiter.sv | 126 ++++++++++++
 tb/tb_axi_rd_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types for the AXI read arbiter: FSM state encoding, read owner,
// the registered AR field bundle and the fixed AXI burst type.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_fields_t;

  localparam logic [1:0] INCR = 2'b01;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive data grants made while inst was waiting.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_inc       : a data grant happened with inst requesting
//   i_clr       : an inst grant happened
//   o_force     : counter saturated; inst must win the next conflict
module arb_starve_cnt #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_force
);

  localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)                       r_cnt <= '0;
    else if (i_clr)                  r_cnt <= '0;
    else if (i_inc && r_cnt != MAX_C) r_cnt <= r_cnt + 1'b1;
  end

  assign o_force = (r_cnt == MAX_C);

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master (inst / data) AXI read arbiter onto one shared AR/R channel.
// One read outstanding at a time: IDLE grants, ADDR presents AR, DATA routes
// R beats to the owner until the rlast handshake.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   i_ar* / i_arready             : inst AR request / accept
//   i_r* / i_rready               : inst R beat out / accept in
//   d_ar* / d_arready             : data AR request / accept
//   d_r* / d_rready               : data R beat out / accept in
//   d_wr_pending                  : data write in flight; blocks data reads
//   m_ar* / m_arready             : shared AR channel
//   m_r* / m_rready               : shared R channel
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [3:0]  ID_INST    = 4'h0,
  parameter logic [3:0]  ID_DATA    = 4'h1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_arvalid,
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  input  logic        d_arvalid,
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic [2:0]  d_arsize,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  input  logic        d_wr_pending,
  output logic [3:0]  m_arid,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready
);

  state_e     r_state;
  owner_e     r_owner;
  ar_fields_t r_ar;

  logic w_idle, w_force, w_gnt_i, w_gnt_d, w_in_data, w_own_d, w_to_i, w_to_d;

  // Grants are suppressed during reset so no arready leaks out while the
  // FSM is being forced back to IDLE.
  assign w_idle  = (r_state == ST_IDLE) && !reset;
  // A pending data write blocks data reads (read-after-write ordering).
  assign w_gnt_d = w_idle && d_arvalid && !d_wr_pending && !(i_arvalid && w_force);
  assign w_gnt_i = w_idle && i_arvalid && !w_gnt_d;

  assign i_arready = w_gnt_i;
  assign d_arready = w_gnt_d;

  arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .reset  (reset),
    .i_inc  (w_gnt_d && i_arvalid),
    .i_clr  (w_gnt_i),
    .o_force(w_force)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_INST;
      r_ar    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_d) begin
            r_owner <= OWN_DATA;
            r_ar    <= '{addr: d_araddr, len: d_arlen, size: d_arsize};
            r_state <= ST_ADDR;
          end else if (w_gnt_i) begin
            r_owner <= OWN_INST;
            r_ar    <= '{addr: i_araddr, len: i_arlen, size: i_arsize};
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: if (m_arready) r_state <= ST_DATA;
        ST_DATA: if (m_rvalid && m_rready && m_rlast) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_arvalid = (r_state == ST_ADDR);
  assign m_arid    = (r_owner == OWN_DATA) ? ID_DATA : ID_INST;
  assign m_araddr  = r_ar.addr;
  assign m_arlen   = r_ar.len;
  assign m_arsize  = r_ar.size;
  assign m_arburst = m_arvalid ? INCR : 2'b00;

  // R routing: only the owner sees beats, and only in DATA; stray beats in
  // IDLE/ADDR are neither forwarded nor accepted.
  assign w_in_data = (r_state == ST_DATA);
  assign w_own_d   = (r_owner == OWN_DATA);
  assign w_to_i    = w_in_data && !w_own_d;
  assign w_to_d    = w_in_data &&  w_own_d;

  assign m_rready = w_own_d ? (w_to_d && d_rready) : (w_to_i && i_rready);

  assign i_rvalid = w_to_i && m_rvalid;
  assign i_rlast  = w_to_i && m_rlast;
  assign i_rdata  = w_to_i ? m_rdata : '0;
  assign d_rvalid = w_to_d && m_rvalid;
  assign d_rlast  = w_to_d && m_rlast;
  assign d_rdata  = w_to_d ? m_rdata : '0;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_arvalid = 0, d_arvalid = 0, d_wr_pending = 0;
  logic [31:0] i_araddr = 0, d_araddr = 0;
  logic [7:0]  i_arlen = 0, d_arlen = 0;
  logic [2:0]  i_arsize = 0, d_arsize = 0;
  logic        i_rready = 0, d_rready = 0;
  logic        m_arready = 0, m_rlast = 0, m_rvalid = 0;
  logic [31:0] m_rdata = 0;
  logic        i_arready, i_rlast, i_rvalid, d_arready, d_rlast, d_rvalid;
  logic [31:0] i_rdata, d_rdata, m_araddr;
  logic [3:0]  m_arid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid, m_rready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.STARVE_MAX(4), .ID_INST(4'h0), .ID_DATA(4'h1)) dut (
    .clk(clk), .reset(reset),
    .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arready(i_arready), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
    .i_rready(i_rready),
    .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
    .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid),
    .d_rready(d_rready), .d_wr_pending(d_wr_pending),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  typedef struct {
    logic        i_v, d_v, pend;
    logic [7:0]  len;
    logic [31:0] i_addr, d_addr;
    logic        exp_i, exp_d;
    logic [3:0]  exp_id;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Called one step after the grant edge: FSM is in ADDR.
  task automatic ar_phase(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    m_arready = 0;
    #2;
    chk("ar_valid", 32'(m_arvalid), 32'd1);
    chk("ar_id", 32'(m_arid), 32'(id));
    chk("ar_addr", m_araddr, addr);
    chk("ar_len", 32'(m_arlen), 32'(len));
    chk("ar_size", 32'(m_arsize), 32'd2);
    chk("ar_burst", 32'(m_arburst), 32'd1);
    chk("ar_no_grant", 32'({i_arready, d_arready}), 32'd0);
    tick; #2;
    chk("ar_hold_valid", 32'(m_arvalid), 32'd1);
    chk("ar_hold_addr", m_araddr, addr);
    m_arready = 1;
    tick;
    m_arready = 0;
  endtask

  // Delivers len+1 beats; optional 3-cycle owner stall at beat stall_at.
  task automatic r_phase(input logic own_d, input logic [7:0] len, input logic [31:0] base,
                         input int stall_at);
    for (int k = 0; k <= int'(len); k++) begin
      m_rvalid = 1; m_rdata = base + 32'(k); m_rlast = (k == int'(len));
      i_rready = !own_d; d_rready = own_d;
      if (k == stall_at) begin
        i_rready = 0; d_rready = 0;
        for (int s = 0; s < 3; s++) begin
          #2;
          chk("stall_mrready", 32'(m_rready), 32'd0);
          chk("stall_rdata", own_d ? d_rdata : i_rdata, base + 32'(k));
          chk("stall_rvalid", 32'(own_d ? d_rvalid : i_rvalid), 32'd1);
          tick;
        end
        i_rready = !own_d; d_rready = own_d;
      end
      #2;
      chk("r_valid", 32'(own_d ? d_rvalid : i_rvalid), 32'd1);
      chk("r_data", own_d ? d_rdata : i_rdata, base + 32'(k));
      chk("r_last", 32'(own_d ? d_rlast : i_rlast), 32'(k == int'(len)));
      chk("r_other_valid", 32'(own_d ? i_rvalid : d_rvalid), 32'd0);
      chk("r_mrready", 32'(m_rready), 32'd1);
      chk("r_no_grant", 32'({i_arready, d_arready}), 32'd0);
      tick;
    end
    m_rvalid = 0; m_rlast = 0; i_rready = 0; d_rready = 0;
    #2;
    chk("post_idle", 32'({m_arvalid, m_rready}), 32'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rdy"}, 32'({i_arready, d_arready}), 32'd0);
    chk({nm, "_rv"}, 32'({i_rvalid, d_rvalid, m_arvalid, m_rready}), 32'd0);
    chk({nm, "_rdata"}, i_rdata | d_rdata, 32'd0);
    chk({nm, "_araddr"}, m_araddr, 32'd0);
    chk({nm, "_arfld"}, 32'({m_arid, m_arlen, m_arsize, m_arburst}), 32'd0);
  endtask

  initial begin
    logic [31:0] IA, DA;
    logic got_d;
    IA = 32'h1FC0_0000;
    DA = 32'h8000_1000;
    i_arsize = 3'd2; d_arsize = 3'd2;

    //            i  d  pnd len  i_addr        d_addr        ei ed id  exp_addr
    tbl[0] = '{1, 0, 0, 8'd3, IA,           DA,           1, 0, 4'h0, IA};
    tbl[1] = '{0, 1, 0, 8'd2, IA,           DA,           0, 1, 4'h1, DA};
    tbl[2] = '{1, 1, 0, 8'd1, IA + 32'h40,  DA + 32'h40,  0, 1, 4'h1, DA + 32'h40};
    tbl[3] = '{1, 1, 1, 8'd1, IA + 32'h80,  DA + 32'h80,  1, 0, 4'h0, IA + 32'h80};
    tbl[4] = '{0, 1, 1, 8'd1, IA,           DA,           0, 0, 4'h0, 32'h0};
    tbl[5] = '{1, 0, 0, 8'd0, IA + 32'hC0,  DA,           1, 0, 4'h0, IA + 32'hC0};
    tbl[6] = '{1, 1, 0, 8'd0, IA,           DA + 32'hC0,  0, 1, 4'h1, DA + 32'hC0};

    // Reset with a request present: nothing may be granted or driven.
    i_arvalid = 1; i_araddr = IA;
    tick; tick; #2;
    chk_all_zero("reset");
    i_arvalid = 0;
    reset = 0;
    tick;

    // Table-driven single transactions.
    for (int v = 0; v < 7; v++) begin
      i_arvalid = tbl[v].i_v; d_arvalid = tbl[v].d_v; d_wr_pending = tbl[v].pend;
      i_araddr = tbl[v].i_addr; d_araddr = tbl[v].d_addr;
      i_arlen = tbl[v].len; d_arlen = tbl[v].len;
      #2;
      chk($sformatf("v%0d_i_arready", v), 32'(i_arready), 32'(tbl[v].exp_i));
      chk($sformatf("v%0d_d_arready", v), 32'(d_arready), 32'(tbl[v].exp_d));
      tick;
      i_arvalid = 0; d_arvalid = 0; d_wr_pending = 0;
      if (!tbl[v].exp_i && !tbl[v].exp_d) begin
        #2;
        chk($sformatf("v%0d_no_ar", v), 32'(m_arvalid), 32'd0);
        tick;
      end else begin
        ar_phase(tbl[v].exp_id, tbl[v].exp_addr, tbl[v].len);
        r_phase(tbl[v].exp_d, tbl[v].len, tbl[v].exp_addr ^ 32'hA5A5_0000, -1);
      end
    end

    // Starvation: both requesting for 6 reads; inst must be the 5th grant.
    // Also checks no grant during the rlast cycle and grant the cycle after.
    reset = 1; tick; reset = 0;
    i_arvalid = 1; d_arvalid = 1; i_araddr = IA; d_araddr = DA;
    i_arlen = 0; d_arlen = 0;
    for (int t = 0; t < 6; t++) begin
      #2;
      chk($sformatf("starve%0d_d", t), 32'(d_arready), 32'(t != 4));
      chk($sformatf("starve%0d_i", t), 32'(i_arready), 32'(t == 4));
      got_d = d_arready;
      tick;
      if (!got_d) i_arvalid = 0;
      ar_phase(got_d ? 4'h1 : 4'h0, got_d ? DA : IA, 8'd0);
      r_phase(got_d, 8'd0, 32'h5000_0000 + 32'(t), -1);
    end
    i_arvalid = 0; d_arvalid = 0;
    tick;

    // Owner back-pressure mid-burst: 3 stalled cycles on beat 1.
    i_arvalid = 1; i_araddr = IA; i_arlen = 3;
    #2;
    chk("bp_grant", 32'(i_arready), 32'd1);
    tick;
    i_arvalid = 0;
    ar_phase(4'h0, IA, 8'd3);
    r_phase(1'b0, 8'd3, 32'hBEEF_0000, 1);

    // Reset after 2 of 4 data beats: transfer abandoned, later beats dropped.
    tick;
    d_arvalid = 1; d_araddr = DA; d_arlen = 3;
    #2;
    chk("rst_mid_grant", 32'(d_arready), 32'd1);
    tick;
    d_arvalid = 0;
    ar_phase(4'h1, DA, 8'd3);
    for (int k = 0; k < 2; k++) begin
      m_rvalid = 1; m_rdata = 32'hCAFE_0000 + 32'(k); m_rlast = 0; d_rready = 1;
      #2;
      chk("rst_mid_beat", d_rdata, 32'hCAFE_0000 + 32'(k));
      tick;
    end
    m_rdata = 32'hCAFE_0002;
    reset = 1;
    tick; #2;
    chk_all_zero("rst_mid");
    reset = 0;
    for (int k = 2; k < 4; k++) begin
      m_rvalid = 1; m_rdata = 32'hCAFE_0000 + 32'(k); m_rlast = (k == 3);
      #2;
      chk("rst_drop_valid", 32'({d_rvalid, i_rvalid, m_rready}), 32'd0);
      chk("rst_drop_data", d_rdata, 32'd0);
      tick;
    end
    m_rvalid = 0; m_rlast = 0; d_rready = 0;

    // Fresh grant works after the abandoned transfer.
    i_arvalid = 1; i_araddr = IA + 32'h100; i_arlen = 0;
    #2;
    chk("post_rst_grant", 32'(i_arready), 32'd1);
    tick;
    i_arvalid = 0;
    ar_phase(4'h0, IA + 32'h100, 8'd0);
    r_phase(1'b0, 8'd0, 32'h1234_5678, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
